mem_wb_forward_pipe: RTL and testbench
======================================

// Module: mem_wb_forward_pipe
// PURPOSE
//  Producer side of the EX-stage forwarding interface. Registers EX results into MEM and WB stages.
//  Drives the data-memory request handshake and holds the pipe on memory wait.
//  Selects the WB write-back data. Outputs rdAddr/RegWrite/ALUResult_mem and rdAddr/RegWrite/RegWriteData_wb.
// PARAMETERS
//  DATA_W  32  datapath width
//  REG_W   5   register-address width
// PORTS
//  clk              in   1       sole clock, rising edge
//  rst_n            in   1       asynchronous, active-low reset
//  ALUResult_ex     in   DATA_W  EX result; memory address for loads and stores
//  MemWriteData_ex  in   DATA_W  forwarded store data
//  rdAddr_ex        in   REG_W   destination register
//  RegWrite_ex      in   1       writes the register file
//  MemRead_ex       in   1       load
//  MemWrite_ex      in   1       store
//  MemtoReg_ex      in   1       WB data is memory data, not ALU data
//  rs1Addr_id       in   REG_W   ID source register 1, for load-use check
//  rs2Addr_id       in   REG_W   ID source register 2, for load-use check
//  dmem_req         out  1       memory request valid
//  dmem_we          out  1       request is a write
//  dmem_addr        out  DATA_W  = ALUResult_mem
//  dmem_wdata       out  DATA_W  store data held in MEM
//  dmem_rdata       in   DATA_W  read data, valid when dmem_ready=1
//  dmem_ready       in   1       request accepted/complete this cycle
//  ALUResult_mem    out  DATA_W  MEM-stage ALU result
//  rdAddr_mem       out  REG_W   MEM-stage destination register
//  RegWrite_mem     out  1       MEM-stage register write enable
//  rdAddr_wb        out  REG_W   WB-stage destination register
//  RegWrite_wb      out  1       WB-stage register write enable
//  RegWriteData_wb  out  DATA_W  WB-stage write-back data
//  mem_stall        out  1       freeze IF/ID/EX and this block's MEM register
//  load_use_stall   out  1       insert one EX bubble
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all MEM/WB registers 0; FSM -> IDLE
//   - dmem_req=0, mem_stall=0, RegWrite_mem/_wb=0; effect is immediate, no clock edge needed.
//  MEM register loads all *_ex inputs on each rising edge with mem_stall=0; holds when mem_stall=1.
//  memop = MemRead_mem|MemWrite_mem. dmem_req = memop; dmem_we = MemWrite_mem.
//  FSM IDLE:
//   - memop & dmem_ready -> stay IDLE, no stall (single-cycle memory)
//   - memop & !dmem_ready -> mem_stall=1 (combinational, same cycle), next WAIT
//  FSM WAIT:
//   - dmem_req held with address/data stable
//   - mem_stall = !dmem_ready
//   - on dmem_ready -> IDLE, pipe advances that edge
//  WB register:
//   - loads on edges with mem_stall=0
//   - during a stall, WB holds its contents, so forwarding from WB stays valid for the frozen EX instruction.
//     Rewriting the same register value is harmless.
//   - RegWriteData_wb: registered MemtoReg_mem ? dmem_rdata : ALUResult_mem, captured on the advancing edge.
//  Latency: EX->MEM 1 cycle, MEM->WB 1 cycle plus wait cycles. No bubbles are generated internally.
//  Non-memop in MEM: dmem_req=0, dmem_ready ignored.
//  Reset mid-WAIT: request aborted, FSM IDLE, in-flight instruction discarded.
//  rdAddr=0 is passed through unchanged; consumers ignore x0.
// CONFIGURATION
//  LOAD_USE_STALL_EN defined:
//   - load_use_stall = MemRead_ex & RegWrite_ex & (rdAddr_ex!=0) & (rdAddr_ex==rs1Addr_id | rdAddr_ex==rs2Addr_id)
//   - forced to 0 while mem_stall=1 (the freeze already covers it)
//  Not defined: load_use_stall tied 0. The compiler schedules a NOP after every load.
// STRUCTURE
//  Shared package:
//   - FSM state enum {IDLE, WAIT}
//   - DATA_W/REG_W defaults
//   - mem_stage_t / wb_stage_t bundle typedefs
//  Sub-module dmem_handshake_fsm: state register, dmem_req/mem_stall generation.
//  Pipeline registers stay in the top module.
// TESTING
//  - ALU op, x5=0x10, RegWrite_ex=1 -> RegWrite_mem=1, rdAddr_mem=5, then RegWriteData_wb=0x10 one cycle later.
//  - Load, dmem_ready=1 same cycle, rdata=0xDEADBEEF -> no stall; RegWriteData_wb=0xDEADBEEF after 2 edges.
//  - Load with dmem_ready low 3 cycles -> mem_stall=1 for exactly 3 cycles; dmem_addr stable;
//    WB outputs unchanged throughout; data captured on the 4th edge.
//  - LOAD_USE_STALL_EN: load x7, then rs2Addr_id=7 -> load_use_stall=1; rdAddr_ex=0 -> 0; rs1Addr_id=8 -> 0.
//  - rst_n low during WAIT -> dmem_req, mem_stall, RegWrite_mem/_wb drop to 0 before the next edge; FSM IDLE.
//  - Store with dmem_ready=1 -> dmem_we=1, dmem_wdata=MemWriteData_ex value, RegWrite_wb=0.

Source files
------------

// File: rtl/mem_wb_forward_pipe_pkg.sv
// Shared types for the MEM/WB forwarding pipe: handshake FSM states, default widths
// and the MEM/WB stage register bundles.
package mem_wb_forward_pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dmem_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] alu_result;
        logic [DATA_W_DEF-1:0] wdata;
        logic [REG_W_DEF-1:0]  rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } mem_stage_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] wdata;
        logic [REG_W_DEF-1:0]  rd;
        logic                  reg_write;
    } wb_stage_t;

endpackage

// File: rtl/mem_wb_forward_pipe_dmem_handshake_fsm.sv
// Data-memory handshake: tracks an outstanding request and raises mem_stall
// in the same cycle the memory fails to answer.
module dmem_handshake_fsm
    import mem_wb_forward_pipe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic memop,
    input  logic dmem_ready,
    output logic dmem_req,
    output logic mem_stall
);

    dmem_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (memop && !dmem_ready) state <= WAIT;
                WAIT: if (dmem_ready)           state <= IDLE;
                default:                        state <= IDLE;
            endcase
        end
    end

    // The stall must be seen by IF/ID/EX before the edge, so it cannot be registered.
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            IDLE:    mem_stall = memop & ~dmem_ready;
            WAIT:    mem_stall = ~dmem_ready;
            default: mem_stall = 1'b0;
        endcase
    end

    assign dmem_req = memop;

endmodule

// File: rtl/mem_wb_forward_pipe.sv
// EX->MEM->WB pipeline registers with data-memory handshake and WB data select.
// Optional load-use hazard detection is enabled by defining LOAD_USE_STALL_EN.
module mem_wb_forward_pipe
    import mem_wb_forward_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ALUResult_ex,
    input  logic [DATA_W-1:0] MemWriteData_ex,
    input  logic [REG_W-1:0]  rdAddr_ex,
    input  logic              RegWrite_ex,
    input  logic              MemRead_ex,
    input  logic              MemWrite_ex,
    input  logic              MemtoReg_ex,
    input  logic [REG_W-1:0]  rs1Addr_id,
    input  logic [REG_W-1:0]  rs2Addr_id,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [DATA_W-1:0] ALUResult_mem,
    output logic [REG_W-1:0]  rdAddr_mem,
    output logic              RegWrite_mem,
    output logic [REG_W-1:0]  rdAddr_wb,
    output logic              RegWrite_wb,
    output logic [DATA_W-1:0] RegWriteData_wb,
    output logic              mem_stall,
    output logic              load_use_stall
);

    mem_stage_t mem_p0;
    wb_stage_t  wb_p1;
    logic       memop;

    assign memop = mem_p0.mem_read | mem_p0.mem_write;

    dmem_handshake_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .memop      (memop),
        .dmem_ready (dmem_ready),
        .dmem_req   (dmem_req),
        .mem_stall  (mem_stall)
    );

    // EX -> MEM boundary: frozen while the memory is busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_p0 <= '0;
        end else if (!mem_stall) begin
            mem_p0.alu_result <= ALUResult_ex;
            mem_p0.wdata      <= MemWriteData_ex;
            mem_p0.rd         <= rdAddr_ex;
            mem_p0.reg_write  <= RegWrite_ex;
            mem_p0.mem_read   <= MemRead_ex;
            mem_p0.mem_write  <= MemWrite_ex;
            mem_p0.mem_to_reg <= MemtoReg_ex;
        end
    end

    // MEM -> WB boundary: held during a stall so WB forwarding stays valid for the frozen EX op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_p1 <= '0;
        end else if (!mem_stall) begin
            wb_p1.wdata     <= mem_p0.mem_to_reg ? dmem_rdata : mem_p0.alu_result;
            wb_p1.rd        <= mem_p0.rd;
            wb_p1.reg_write <= mem_p0.reg_write;
        end
    end

    assign dmem_we         = mem_p0.mem_write;
    assign dmem_addr       = mem_p0.alu_result;
    assign dmem_wdata      = mem_p0.wdata;
    assign ALUResult_mem   = mem_p0.alu_result;
    assign rdAddr_mem      = mem_p0.rd;
    assign RegWrite_mem    = mem_p0.reg_write;
    assign rdAddr_wb       = wb_p1.rd;
    assign RegWrite_wb     = wb_p1.reg_write;
    assign RegWriteData_wb = wb_p1.wdata;

`ifdef LOAD_USE_STALL_EN
    logic lu_hit;
    assign lu_hit = MemRead_ex & RegWrite_ex & (rdAddr_ex != '0) &
                    ((rdAddr_ex == rs1Addr_id) | (rdAddr_ex == rs2Addr_id));
    // A memory freeze already holds EX, so no extra bubble is requested then.
    assign load_use_stall = lu_hit & ~mem_stall;
`else
    logic unused_rs;
    assign unused_rs      = ^{rs1Addr_id, rs2Addr_id};
    assign load_use_stall = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_forward_pipe.sv
// Directed bench for mem_wb_forward_pipe with hand-computed expectations;
// covers both builds of LOAD_USE_STALL_EN.
module tb_mem_wb_forward_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALUResult_ex, MemWriteData_ex, dmem_rdata;
    logic [4:0]  rdAddr_ex, rs1Addr_id, rs2Addr_id;
    logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, dmem_ready;
    logic        dmem_req, dmem_we, RegWrite_mem, RegWrite_wb, mem_stall, load_use_stall;
    logic [31:0] dmem_addr, dmem_wdata, ALUResult_mem, RegWriteData_wb;
    logic [4:0]  rdAddr_mem, rdAddr_wb;

    int n_checks = 0;
    int n_errors = 0;

    mem_wb_forward_pipe dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ALUResult_ex    (ALUResult_ex),
        .MemWriteData_ex (MemWriteData_ex),
        .rdAddr_ex       (rdAddr_ex),
        .RegWrite_ex     (RegWrite_ex),
        .MemRead_ex      (MemRead_ex),
        .MemWrite_ex     (MemWrite_ex),
        .MemtoReg_ex     (MemtoReg_ex),
        .rs1Addr_id      (rs1Addr_id),
        .rs2Addr_id      (rs2Addr_id),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ready      (dmem_ready),
        .ALUResult_mem   (ALUResult_mem),
        .rdAddr_mem      (rdAddr_mem),
        .RegWrite_mem    (RegWrite_mem),
        .rdAddr_wb       (rdAddr_wb),
        .RegWrite_wb     (RegWrite_wb),
        .RegWriteData_wb (RegWriteData_wb),
        .mem_stall       (mem_stall),
        .load_use_stall  (load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        ALUResult_ex    = alu;
        MemWriteData_ex = wd;
        rdAddr_ex       = rd;
        RegWrite_ex     = rw;
        MemRead_ex      = mr;
        MemWrite_ex     = mw;
        MemtoReg_ex     = m2r;
    endtask

    initial begin
        rst_n      = 1'b0;
        set_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rs1Addr_id = 5'd0;
        rs2Addr_id = 5'd0;
        dmem_rdata = 32'h0;
        dmem_ready = 1'b0;
        #2;
        check("rst_req",      {31'b0, dmem_req},     32'd0);
        check("rst_stall",    {31'b0, mem_stall},    32'd0);
        check("rst_rw_mem",   {31'b0, RegWrite_mem}, 32'd0);
        check("rst_rw_wb",    {31'b0, RegWrite_wb},  32'd0);
        check("rst_wbdata",   RegWriteData_wb,       32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // ALU op x5 = 0x10
        set_ex(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("alu_rw_mem",   {31'b0, RegWrite_mem}, 32'd1);
        check("alu_rd_mem",   {27'b0, rdAddr_mem},   32'd5);
        check("alu_res_mem",  ALUResult_mem,         32'h10);
        check("alu_no_req",   {31'b0, dmem_req},     32'd0);
        check("alu_no_stall", {31'b0, mem_stall},    32'd0);
        tick();
        check("alu_wbdata",   RegWriteData_wb,       32'h10);
        check("alu_rd_wb",    {27'b0, rdAddr_wb},    32'd5);
        check("alu_rw_wb",    {31'b0, RegWrite_wb},  32'd1);

        // Load x6 from 0x100, memory answers at once
        set_ex(32'h100, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        set_ex(32'h200, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);  // next: load x7 from 0x200
        #1;
        check("ld1_req",      {31'b0, dmem_req},     32'd1);
        check("ld1_we",       {31'b0, dmem_we},      32'd0);
        check("ld1_addr",     dmem_addr,             32'h100);
        check("ld1_no_stall", {31'b0, mem_stall},    32'd0);
        tick();
        check("ld1_wbdata",   RegWriteData_wb,       32'hDEADBEEF);
        check("ld1_rd_wb",    {27'b0, rdAddr_wb},    32'd6);

        // Load x7 with memory busy for three cycles
        dmem_ready = 1'b0;
        dmem_rdata = 32'h12345678;
        set_ex(32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ld2_stall%0d", i),  {31'b0, mem_stall},  32'd1);
            check($sformatf("ld2_addr%0d", i),   dmem_addr,           32'h200);
            check($sformatf("ld2_req%0d", i),    {31'b0, dmem_req},   32'd1);
            check($sformatf("ld2_rdmem%0d", i),  {27'b0, rdAddr_mem}, 32'd7);
            check($sformatf("ld2_wbhold%0d", i), RegWriteData_wb,     32'hDEADBEEF);
            check($sformatf("ld2_rdwb%0d", i),   {27'b0, rdAddr_wb},  32'd6);
            tick();
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1;
        check("ld2_release",  {31'b0, mem_stall},    32'd0);
        check("ld2_wbhold3",  RegWriteData_wb,       32'hDEADBEEF);
        tick();
        check("ld2_wbdata",   RegWriteData_wb,       32'hCAFEF00D);
        check("ld2_rd_wb",    {27'b0, rdAddr_wb},    32'd7);
        check("ld2_next_mem", ALUResult_mem,         32'h55);
        check("ld2_next_rd",  {27'b0, rdAddr_mem},   32'd9);
        dmem_ready = 1'b0;
        set_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("frz_wbdata",   RegWriteData_wb,       32'h55);
        check("frz_rd_wb",    {27'b0, rdAddr_wb},    32'd9);

        // Store 0xA5A50001 to 0x300
        set_ex(32'h300, 32'hA5A50001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_ready = 1'b1;
        #1;
        check("st_req",       {31'b0, dmem_req},     32'd1);
        check("st_we",        {31'b0, dmem_we},      32'd1);
        check("st_wdata",     dmem_wdata,            32'hA5A50001);
        check("st_addr",      dmem_addr,             32'h300);
        check("st_no_stall",  {31'b0, mem_stall},    32'd0);
        tick();
        check("st_rw_wb",     {31'b0, RegWrite_wb},  32'd0);
        dmem_ready = 1'b0;

        // Reset in the middle of a WAIT
        set_ex(32'h77, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_ex(32'h400, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        set_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rw_stall",     {31'b0, mem_stall},    32'd1);
        check("rw_rw_wb",     {31'b0, RegWrite_wb},  32'd1);
        check("rw_rw_mem",    {31'b0, RegWrite_mem}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_req0",      {31'b0, dmem_req},     32'd0);
        check("rw_stall0",    {31'b0, mem_stall},    32'd0);
        check("rw_rw_mem0",   {31'b0, RegWrite_mem}, 32'd0);
        check("rw_rw_wb0",    {31'b0, RegWrite_wb},  32'd0);
        tick();
        rst_n = 1'b1;
        set_ex(32'h99, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("rw_idle",      {31'b0, mem_stall},    32'd0);
        tick();
        check("rw_adv_mem",   ALUResult_mem,         32'h99);
        check("rw_adv_wb",    {27'b0, rdAddr_wb},    32'd0);

        // Load-use detection in the ID stage
        set_ex(32'h500, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        rs1Addr_id = 5'd1;
        rs2Addr_id = 5'd7;
        #1;
`ifdef LOAD_USE_STALL_EN
        check("lu_hit",       {31'b0, load_use_stall}, 32'd1);
`else
        check("lu_off",       {31'b0, load_use_stall}, 32'd0);
`endif
        rdAddr_ex  = 5'd0;
        rs2Addr_id = 5'd0;
        #1;
        check("lu_x0",        {31'b0, load_use_stall}, 32'd0);
        rdAddr_ex  = 5'd7;
        rs1Addr_id = 5'd8;
        rs2Addr_id = 5'd9;
        #1;
        check("lu_miss",      {31'b0, load_use_stall}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
